// File: rtl/regfile_pkg.sv
// Shared definitions for engine register banks: CTRL field positions and launch FSM states.
package regfile_pkg;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_ABORT  = 1;
  localparam int unsigned CTRL_BUSY   = 8;
  localparam int unsigned CTRL_DONE   = 9;
  localparam int unsigned CTRL_ERR    = 10;
  localparam int unsigned CTRL_IRQ_EN = 15;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_e;

endpackage

// File: rtl/regfile_launch_fsm.sv
// Engine launch sequencer: IDLE -> LOAD -> RUN with start/abort pulses and DONE/ERR set strobes.
module regfile_launch_fsm
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start_req,
  input  logic abort_req,
  input  logic done_i,
  output logic load,
  output logic start_o,
  output logic abort_o,
  output logic busy_o,
  output logic done_set,
  output logic err_set
);

  state_e state;

  assign load     = (state == LOAD);
  assign done_set = (state == RUN) && done_i;
  assign err_set  = start_req && (state != IDLE);

  // A completion arriving together with an abort is treated as a normal finish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      start_o <= 1'b0;
      abort_o <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      start_o <= 1'b0;
      abort_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_req) state <= LOAD;
        end
        LOAD: begin
          state   <= RUN;
          start_o <= 1'b1;
          busy_o  <= 1'b1;
        end
        RUN: begin
          if (done_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (abort_req) begin
            state   <= IDLE;
            abort_o <= 1'b1;
            busy_o  <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/regfile_bank_shadow.sv
// Double-buffered config/status register bank: host writes staging, START copies staging into
// cfg_active and launches the engine; offset 0 is CTRL with sticky W1C DONE/ERR and an interrupt.
module regfile_bank_shadow
  import regfile_pkg::*;
#(
  parameter int unsigned            N_REGS    = 16,
  parameter int unsigned            ADDR_W    = 14,
  parameter int unsigned            DATA_W    = 16,
  parameter logic [ADDR_W-1:0]      BASE_ADDR = 14'h300,
  parameter logic [N_REGS-1:0]      RW_MASK   = 16'hFFFE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          write_data,
  output logic [DATA_W-1:0]          read_data,
  output logic                       read_valid,
  output logic [N_REGS*DATA_W-1:0]   cfg_active,
  input  logic [N_REGS*DATA_W-1:0]   sts_in,
  output logic                       start_o,
  output logic                       abort_o,
  output logic                       busy_o,
  input  logic                       done_i,
  output logic                       irq_o
);

  localparam int unsigned OFF_W = $clog2(N_REGS);

  logic [ADDR_W:0]       addr_x, lo, hi;
  logic                  hit;
  logic [OFF_W-1:0]      off;
  logic                  ctrl_wr, rw_wr, ro_wr;
  logic                  start_req, abort_req;
  logic                  load, done_set, err_set;
  logic                  done_q, err_q, irq_en;
  logic [DATA_W-1:0]     ctrl_val, rd_val;
  logic [DATA_W-1:0]     staging [N_REGS];

  assign addr_x = {1'b0, addr};
  assign lo     = {1'b0, BASE_ADDR};
  assign hi     = lo + (ADDR_W+1)'(N_REGS);
  assign hit    = (addr_x >= lo) && (addr_x < hi);
  assign off    = OFF_W'(addr - BASE_ADDR);

  assign ctrl_wr = wr_en && hit && (off == '0);
  assign rw_wr   = wr_en && hit && (off != '0) && RW_MASK[off];
  assign ro_wr   = wr_en && hit && (off != '0) && !RW_MASK[off];

  // ABORT in the same write suppresses START entirely, so it can never raise ERR.
  assign start_req = ctrl_wr && write_data[CTRL_START] && !write_data[CTRL_ABORT];
  assign abort_req = ctrl_wr && write_data[CTRL_ABORT];

  regfile_launch_fsm u_fsm (
    .clk       (clk),
    .rst       (rst),
    .start_req (start_req),
    .abort_req (abort_req),
    .done_i    (done_i),
    .load      (load),
    .start_o   (start_o),
    .abort_o   (abort_o),
    .busy_o    (busy_o),
    .done_set  (done_set),
    .err_set   (err_set)
  );

  always_comb begin
    ctrl_val              = '0;
    ctrl_val[CTRL_BUSY]   = busy_o;
    ctrl_val[CTRL_DONE]   = done_q;
    ctrl_val[CTRL_ERR]    = err_q;
    ctrl_val[CTRL_IRQ_EN] = irq_en;
  end

  always_comb begin
    rd_val = '0;
    if (off == '0)        rd_val = ctrl_val;
    else if (RW_MASK[off]) rd_val = staging[off];
    else                  rd_val = sts_in[int'(off)*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_REGS; i++) staging[i] <= '0;
      cfg_active <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      irq_en     <= 1'b0;
      irq_o      <= 1'b0;
      read_data  <= '0;
      read_valid <= 1'b0;
    end else begin
      if (rw_wr) staging[off] <= write_data;
      if (load) begin
        for (int unsigned i = 1; i < N_REGS; i++) begin
          if (RW_MASK[i]) cfg_active[i*DATA_W +: DATA_W] <= staging[i];
        end
      end
      // Sticky flags: a set in the same cycle as a W1C clear wins.
      done_q <= done_set | (done_q & ~(ctrl_wr & write_data[CTRL_DONE]));
      err_q  <= err_set | ro_wr | (err_q & ~(ctrl_wr & write_data[CTRL_ERR]));
      if (ctrl_wr) irq_en <= write_data[CTRL_IRQ_EN];
      irq_o      <= irq_en & done_q;
      read_valid <= rd_en && hit;
      if (rd_en && hit) read_data <= rd_val;
    end
  end

endmodule
